// File: rtl/uart_rx_char_feeder.sv
// uart_rx_char_feeder: 8N1 UART receiver feeding a byte FIFO, replayed as
// single-cycle CHAR/WE strobes spaced at least GAP_CYCLES apart.
// Optional build macro UART_PARITY_EN switches the frame to 8E1 and drops
// bytes whose parity is wrong (FRAME_ERR pulses at the stop-bit sample).
module uart_rx_char_feeder #(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 64
) (
  input  logic                          CLK_50MHz,
  input  logic                          RESET,
  input  logic                          RX,
  output logic [7:0]                    CHAR,
  output logic                          WE,
  output logic                          FRAME_ERR,
  output logic                          OVERFLOW,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT
);
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int DW  = $clog2(DIV + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int GW  = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, WAIT_IDLE
`ifdef UART_PARITY_EN
    , PARITY
`endif
  } state_t;

  logic          rx_meta, rxs, rxs_d;
  logic [DW-1:0] div_cnt;
  logic          tick;
  state_t        state, state_n;
  logic [3:0]    tick_cnt, tick_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shreg, sh_n;
  logic          push, ferr_n;
`ifdef UART_PARITY_EN
  logic          par_err, perr_n;
`endif

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, pop, do_push;
  logic [GW-1:0] gap_cnt;

  // Two-flop synchroniser plus one delayed copy for falling-edge detect
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= RX;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign tick = (div_cnt == DW'(DIV - 1));

  // Free-running 16x oversample divider
  always_ff @(posedge CLK_50MHz) begin
    if (RESET)     div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end

  // Receiver state register
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      FRAME_ERR <= 1'b0;
`ifdef UART_PARITY_EN
      par_err  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shreg    <= sh_n;
      FRAME_ERR <= ferr_n;
`ifdef UART_PARITY_EN
      par_err  <= perr_n;
`endif
    end
  end

  // Receiver next-state: samples at tick 8 of start, then every 16th tick (mid-bit)
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    push    = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_PARITY_EN
    perr_n  = par_err;
`endif
    case (state)
      IDLE: begin
        if (rxs_d && !rxs) begin
          state_n = START;
          tick_n  = '0;
        end
      end
      START: begin
        if (tick) begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd7) begin
            if (rxs) state_n = IDLE;
            else begin
              state_n = DATA;
              tick_n  = '0;
              bit_n   = '0;
            end
          end
        end
      end
      DATA: begin
        if (tick) begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            sh_n  = {rxs, shreg[7:1]};
            bit_n = bit_cnt + 3'd1;
`ifdef UART_PARITY_EN
            if (bit_cnt == 3'd7) state_n = PARITY;
`else
            if (bit_cnt == 3'd7) state_n = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (tick) begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            perr_n  = ^shreg ^ rxs;
            state_n = STOP;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) begin
            if (!rxs) begin
              ferr_n  = 1'b1;
              state_n = WAIT_IDLE;
              tick_n  = '0;
`ifdef UART_PARITY_EN
            end else if (par_err) begin
              ferr_n  = 1'b1;
              state_n = IDLE;
`endif
            end else begin
              push    = 1'b1;
              state_n = IDLE;
            end
          end
        end
      end
      WAIT_IDLE: begin
        // A stuck-low line must be seen high for a full bit before re-arming
        if (!rxs) tick_n = '0;
        else if (tick) begin
          tick_n = tick_cnt + 4'd1;
          if (tick_cnt == 4'd15) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign full    = (FIFO_COUNT == (AW + 1)'(FIFO_DEPTH));
  // Blocking pop while WE is high keeps strobes apart even with GAP_CYCLES=1
  assign pop     = (FIFO_COUNT != '0) && (gap_cnt == '0) && !WE;
  assign do_push = push && (!full || pop);

  // FIFO storage; stale entries are harmless since pointers reset
  always_ff @(posedge CLK_50MHz) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      FIFO_COUNT <= '0;
      OVERFLOW   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   FIFO_COUNT <= FIFO_COUNT + 1'b1;
        2'b01:   FIFO_COUNT <= FIFO_COUNT - 1'b1;
        default: FIFO_COUNT <= FIFO_COUNT;
      endcase
      if (push && !do_push) OVERFLOW <= 1'b1;
    end
  end

  // Output register and pacing gap counter
  always_ff @(posedge CLK_50MHz) begin
    if (RESET) begin
      CHAR    <= '0;
      WE      <= 1'b0;
      gap_cnt <= '0;
    end else begin
      WE <= pop;
      if (pop) CHAR <= mem[rd_ptr];
      if (pop)                 gap_cnt <= GW'(GAP_CYCLES - 1);
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GW'(1);
    end
  end
endmodule

// File: tb/tb_uart_rx_char_feeder.sv
// Directed bench: instance A runs at the default 115200 baud / GAP 64,
// instance B runs fast (16 cycles per bit, GAP 1300) for overflow and reset.
module tb_uart_rx_char_feeder;
  localparam int BIT_A = 432;
  localparam int BIT_B = 16;
  localparam int GAP_B = 1300;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_a, rst_b, rx_a, rx_b;
  logic [7:0] char_a, char_b;
  logic       we_a, we_b, fe_a, fe_b, ov_a, ov_b;
  logic [4:0] cnt_a, cnt_b;

  uart_rx_char_feeder dut_a (
    .CLK_50MHz(clk), .RESET(rst_a), .RX(rx_a), .CHAR(char_a), .WE(we_a),
    .FRAME_ERR(fe_a), .OVERFLOW(ov_a), .FIFO_COUNT(cnt_a));

  uart_rx_char_feeder #(.CLK_HZ(50000000), .BAUD(3125000), .FIFO_DEPTH(16),
                        .GAP_CYCLES(GAP_B)) dut_b (
    .CLK_50MHz(clk), .RESET(rst_b), .RX(rx_b), .CHAR(char_b), .WE(we_b),
    .FRAME_ERR(fe_b), .OVERFLOW(ov_b), .FIFO_COUNT(cnt_b));

  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] got_a[$], got_b[$];
  int tw_a[$], tw_b[$], lat_a[$];
  int fe_cnt_a = 0, fe_cnt_b = 0, rise_a = 0, max_b = 0, nb = 0;
  logic we_a_prev = 1'b0, we_b_prev = 1'b0, cnt_a_nz = 1'b0;
`ifdef UART_PARITY_EN
  logic par_flip = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records strobes, their cycle, and push-to-WE latency
  always @(negedge clk) begin
    if (we_a) begin
      got_a.push_back(char_a); tw_a.push_back(cyc); lat_a.push_back(cyc - rise_a);
      chk("a_we_back_to_back", {31'd0, we_a_prev}, 32'd0);
    end
    if (we_b) begin
      got_b.push_back(char_b); tw_b.push_back(cyc);
      chk("b_we_back_to_back", {31'd0, we_b_prev}, 32'd0);
    end
    if (cnt_a != 0 && !cnt_a_nz) rise_a = cyc;
    cnt_a_nz = (cnt_a != 0);
    we_a_prev = we_a;
    we_b_prev = we_b;
    if (fe_a) fe_cnt_a++;
    if (fe_b) fe_cnt_b++;
    if (int'(cnt_b) > max_b) max_b = int'(cnt_b);
  end

  function automatic logic [31:0] at_a(input int i);
    return (i < got_a.size()) ? {24'd0, got_a[i]} : 32'hDEAD;
  endfunction
  function automatic logic [31:0] at_b(input int i);
    return (i < got_b.size()) ? {24'd0, got_b[i]} : 32'hDEAD;
  endfunction
  function automatic logic [7:0] sent_b(input int i);
    logic [31:0] v;
    v = 32'h7F + i * 37;
    return v[7:0];
  endfunction

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) rx_b = v; else rx_a = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] b, input logic stop);
    int bt;
    bt = sel ? BIT_B : BIT_A;
    drive(sel, 1'b0, bt);
    for (int i = 0; i < 8; i++) drive(sel, b[i], bt);
`ifdef UART_PARITY_EN
    drive(sel, ^b ^ par_flip, bt);
`endif
    drive(sel, stop, bt);
  endtask

  task automatic wait_we(input bit sel, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((sel ? got_b.size() : got_a.size()) >= n) break;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [7:0] hi [4];
    hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0D; hi[3] = 8'h0A;
    rst_a = 1'b1; rst_b = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_char", {24'd0, char_a}, 32'h0);
    chk("rst_we", {31'd0, we_a}, 32'h0);
    chk("rst_frame_err", {31'd0, fe_a}, 32'h0);
    chk("rst_overflow", {31'd0, ov_a}, 32'h0);
    chk("rst_count", {27'd0, cnt_a}, 32'h0);
    chk("rst_count_b", {27'd0, cnt_b}, 32'h0);
    rst_a = 1'b0; rst_b = 1'b0;
    drive(0, 1'b1, BIT_A);

    // Single byte
    send(0, 8'h41, 1'b1);
    drive(0, 1'b1, BIT_A);
    wait_we(0, 1, 2000);
    chk("t1_we_count", got_a.size(), 1);
    chk("t1_char", at_a(0), 32'h41);
    chk("t1_latency", (lat_a.size() > 0) ? lat_a[0] : -1, 1);
    chk("t1_frame_err", fe_cnt_a, 0);
    chk("t1_fifo_count", {27'd0, cnt_a}, 0);

    // Back-to-back string
    for (int k = 0; k < 4; k++) send(0, hi[k], 1'b1);
    drive(0, 1'b1, BIT_A);
    wait_we(0, 5, 3000);
    chk("t2_we_count", got_a.size(), 5);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_char%0d", k), at_a(k + 1), {24'd0, hi[k]});
      chk($sformatf("t2_latency%0d", k), (lat_a.size() > k + 1) ? lat_a[k + 1] : -1, 1);
      if (tw_a.size() > k + 1)
        chk($sformatf("t2_gap%0d", k), {31'd0, (tw_a[k + 1] - tw_a[k]) >= 64}, 1);
    end

    // Start-bit glitch shorter than half a bit
    drive(0, 1'b0, 100);
    drive(0, 1'b1, 2 * BIT_A);
    chk("t3_no_we", got_a.size(), 5);
    chk("t3_no_frame_err", fe_cnt_a, 0);

    // Framing error, line held low, then recovery
    send(0, 8'h55, 1'b0);
    drive(0, 1'b0, 2 * BIT_A);
    drive(0, 1'b1, 2 * BIT_A);
    chk("t4_frame_err_once", fe_cnt_a, 1);
    chk("t4_no_we", got_a.size(), 5);
    send(0, 8'h31, 1'b1);
    drive(0, 1'b1, BIT_A);
    wait_we(0, 6, 2000);
    chk("t4_recover_char", at_a(5), 32'h31);
    chk("t4_frame_err_total", fe_cnt_a, 1);

`ifdef UART_PARITY_EN
    par_flip = 1'b1;
    send(0, 8'h03, 1'b1);
    par_flip = 1'b0;
    drive(0, 1'b1, BIT_A);
    chk("par_bad_frame_err", fe_cnt_a, 2);
    chk("par_bad_no_we", got_a.size(), 6);
    send(0, 8'h03, 1'b1);
    drive(0, 1'b1, BIT_A);
    wait_we(0, 7, 2000);
    chk("par_good_char", at_a(6), 32'h03);
    chk("par_good_frame_err", fe_cnt_a, 2);
`endif

    // Overflow on the fast instance
    for (int i = 0; i < 20; i++) send(1, sent_b(i), 1'b1);
    drive(1, 1'b1, BIT_B);
    chk("t5_max_count", max_b, 16);
    chk("t5_count_full", {27'd0, cnt_b}, 16);
    chk("t5_overflow", {31'd0, ov_b}, 1);
    wait_we(1, 12, 20000);
    chk("t5_we_count", got_b.size(), 12);
    for (int i = 0; i < 12; i++)
      chk($sformatf("t5_order%0d", i), at_b(i), {24'd0, sent_b(i)});
    chk("t5_gap_exact", (tw_b.size() > 1) ? tw_b[1] - tw_b[0] : -1, GAP_B);
    chk("t5_overflow_sticky", {31'd0, ov_b}, 1);
    chk("t5_frame_err", fe_cnt_b, 0);

    // Reset mid-data of 0x7E with FIFO still holding bytes
    drive(1, 1'b0, BIT_B);
    drive(1, 1'b0, BIT_B);
    drive(1, 1'b1, BIT_B);
    drive(1, 1'b1, BIT_B / 2);
    rx_b = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clk);
    rst_b = 1'b0;
    nb = got_b.size();
    drive(1, 1'b1, 3 * BIT_B);
    chk("t6_count_cleared", {27'd0, cnt_b}, 0);
    chk("t6_overflow_cleared", {31'd0, ov_b}, 0);
    drive(1, 1'b1, 2 * GAP_B);
    chk("t6_no_we", got_b.size(), nb);
    send(1, 8'h20, 1'b1);
    drive(1, 1'b1, BIT_B);
    wait_we(1, nb + 1, 200);
    chk("t6_we_count", got_b.size(), nb + 1);
    chk("t6_char", at_b(nb), 32'h20);
    chk("t6_overflow", {31'd0, ov_b}, 0);
    chk("t6_count", {27'd0, cnt_b}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
